// File: rtl/sni_match_pkg.sv
// Shared types and constants for the SNI/LDAPS shift-and matcher and its table loader.
package sni_match_pkg;

  localparam int unsigned MASK_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned TBL_DEPTH    = 2 ** ADDR_W_DEF;
  localparam logic [7:0]  WILDCARD_DEF = 8'h2A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_CLEAR,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sni_mask_word_gen.sv
// Table word for the byte at pattern position i_idx: bit i cleared where that position matches it.
module sni_mask_word_gen
  import sni_match_pkg::*;
#(
  parameter  int unsigned MASK_W = MASK_W_DEF,
  localparam int unsigned LEN_W  = $clog2(MASK_W + 1),
  localparam int unsigned IDX_W  = $clog2(MASK_W)
) (
  input  logic [MASK_W-1:0][7:0] i_pat,
  input  logic [LEN_W-1:0]       i_len,
  input  logic [MASK_W-1:0]      i_wc,
  input  logic [IDX_W-1:0]       i_idx,
  output logic [MASK_W-1:0]      o_word_c
);

  always_comb begin
    o_word_c = '1;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if ((LEN_W'(i) < i_len) && (i_wc[i] || (i_pat[i] == i_pat[i_idx]))) begin
        o_word_c[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sni_mask_table_loader.sv
// Captures a pattern, then clears and programs the shift-and mask RAM through one write port.
// Optional SNI_LOADER_READBACK_EN adds a read-back VERIFY pass with sticky o_verify_err.
module sni_mask_table_loader
  import sni_match_pkg::*;
#(
  parameter  int unsigned MASK_W        = MASK_W_DEF,
  parameter  int unsigned ADDR_W        = ADDR_W_DEF,
  parameter  logic [7:0]  WILDCARD_BYTE = WILDCARD_DEF,
  localparam int unsigned LEN_W         = $clog2(MASK_W + 1),
  localparam int unsigned IDX_W         = $clog2(MASK_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_start,
  input  logic              i_pat_valid,
  input  logic [7:0]        i_pat_data,
  input  logic              i_pat_last,
  output logic              o_pat_ready,
  output logic              o_tbl_we,
  output logic [ADDR_W-1:0] o_tbl_addr,
  output logic [MASK_W-1:0] o_tbl_din,
  output logic [MASK_W-1:0] o_wc_mask,
  output logic [IDX_W-1:0]  o_accept_idx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
`ifdef SNI_LOADER_READBACK_EN
  ,
  input  logic [MASK_W-1:0] i_tbl_dout,
  output logic              o_verify_err
`endif
);

  state_e                  state_q, state_d;
  logic [MASK_W-1:0][7:0]  pat_q, pat_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [MASK_W-1:0]       wc_q, wc_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0]        j_q, j_d;
  logic [IDX_W-1:0]        acc_q, acc_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [MASK_W-1:0]       din_q, din_d;
  logic [MASK_W-1:0]       word_c;
  logic [IDX_W-1:0]        jx_c;
  logic                    xfer_c;

  assign jx_c   = j_q[IDX_W-1:0];
  assign xfer_c = i_pat_valid && ready_q;

  sni_mask_word_gen #(.MASK_W(MASK_W)) u_word_gen (
    .i_pat    (pat_q),
    .i_len    (len_q),
    .i_wc     (wc_q),
    .i_idx    (jx_c),
    .o_word_c (word_c)
  );

`ifdef SNI_LOADER_READBACK_EN
  logic              chk1_q, chk1_d, chk2_q, verr_q;
  logic [MASK_W-1:0] exp1_q, exp1_d, exp2_q;
`endif

  // Next state; write-port outputs are registered from the current state, one cycle behind it.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    wc_d    = wc_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    acc_d   = acc_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = '0;
    din_d   = '0;
`ifdef SNI_LOADER_READBACK_EN
    chk1_d  = 1'b0;
    exp1_d  = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_cfg_start) begin
          state_d = ST_CAPTURE;
          err_d   = 1'b0;
          pat_d   = '0;
          len_d   = '0;
          wc_d    = '0;
          acc_d   = '0;
        end
      end
      ST_CAPTURE: begin
        if (xfer_c) begin
          if (len_q == LEN_W'(MASK_W)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pat_d[len_q[IDX_W-1:0]] = i_pat_data;
            if (i_pat_data == WILDCARD_BYTE) wc_d[len_q[IDX_W-1:0]] = 1'b1;
            len_d = len_q + LEN_W'(1);
            acc_d = len_q[IDX_W-1:0];
            if (i_pat_last) begin
              state_d = ST_CLEAR;
              cnt_d   = '0;
            end
          end
        end
      end
      ST_CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        din_d  = ~wc_q;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = ST_WRITE;
          j_d     = '0;
        end
      end
      ST_WRITE: begin
        we_d   = !wc_q[jx_c];
        addr_d = ADDR_W'(pat_q[jx_c]);
        din_d  = word_c;
        j_d    = j_q + LEN_W'(1);
        if (j_q == len_q - LEN_W'(1)) begin
`ifdef SNI_LOADER_READBACK_EN
          state_d = ST_VERIFY;
`else
          state_d = ST_DONE;
`endif
          j_d = '0;
        end
      end
`ifdef SNI_LOADER_READBACK_EN
      // One extra cycle beyond len covers the RAM read latency of the last compare.
      ST_VERIFY: begin
        if (j_q < len_q) begin
          addr_d = ADDR_W'(pat_q[jx_c]);
          chk1_d = !wc_q[jx_c];
          exp1_d = word_c;
        end
        j_d = j_q + LEN_W'(1);
        if (j_q == len_q) state_d = ST_DONE;
      end
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_CAPTURE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      wc_q    <= '0;
      cnt_q   <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

`ifdef SNI_LOADER_READBACK_EN
  // Expected word travels alongside the read address, then waits one cycle for the RAM data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chk1_q <= 1'b0;
      chk2_q <= 1'b0;
      exp1_q <= '0;
      exp2_q <= '0;
      verr_q <= 1'b0;
    end else begin
      chk1_q <= chk1_d;
      exp1_q <= exp1_d;
      chk2_q <= chk1_q;
      exp2_q <= exp1_q;
      if (state_q == ST_IDLE && i_cfg_start) verr_q <= 1'b0;
      else if (chk2_q && (i_tbl_dout != exp2_q)) verr_q <= 1'b1;
    end
  end

  assign o_verify_err = verr_q;
`endif

  assign o_pat_ready  = ready_q;
  assign o_tbl_we     = we_q;
  assign o_tbl_addr   = addr_q;
  assign o_tbl_din    = din_q;
  assign o_wc_mask    = wc_q;
  assign o_accept_idx = acc_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_sni_mask_table_loader.sv
// Randomized self-checking bench for sni_mask_table_loader against a per-address table model.
module tb_sni_mask_table_loader;
  import sni_match_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_cfg_start, i_pat_valid, i_pat_last;
  logic [7:0] i_pat_data;
  logic       o_pat_ready, o_tbl_we, o_busy, o_done, o_err;
  logic [7:0] o_tbl_addr, o_tbl_din, o_wc_mask;
  logic [2:0] o_accept_idx;
`ifdef SNI_LOADER_READBACK_EN
  logic [7:0] i_tbl_dout;
  logic       o_verify_err;
  logic       corrupt_b = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  sni_mask_table_loader dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_cfg_start  (i_cfg_start),
    .i_pat_valid  (i_pat_valid),
    .i_pat_data   (i_pat_data),
    .i_pat_last   (i_pat_last),
    .o_pat_ready  (o_pat_ready),
    .o_tbl_we     (o_tbl_we),
    .o_tbl_addr   (o_tbl_addr),
    .o_tbl_din    (o_tbl_din),
    .o_wc_mask    (o_wc_mask),
    .o_accept_idx (o_accept_idx),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
`ifdef SNI_LOADER_READBACK_EN
    ,
    .i_tbl_dout   (i_tbl_dout),
    .o_verify_err (o_verify_err)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned we_cnt = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  ram [TBL_DEPTH];
  logic [7:0]  cur_pat [$];

  // Behavioural mask RAM: synchronous write, 1-cycle read on the same address.
  always @(posedge i_clk) begin
    if (o_tbl_we) ram[o_tbl_addr] <= o_tbl_din;
`ifdef SNI_LOADER_READBACK_EN
    i_tbl_dout <= ram[o_tbl_addr] ^ ((corrupt_b && o_tbl_addr == 8'h62) ? 8'h01 : 8'h00);
`endif
  end

  always @(negedge i_clk) begin
    if (o_tbl_we === 1'b1) we_cnt++;
    if (o_done === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: address b holds bit i = 0 iff position i is a wildcard or equals b.
  function automatic logic [7:0] exp_word(input logic [7:0] b);
    exp_word = 8'hFF;
    for (int i = 0; i < cur_pat.size(); i++)
      if (cur_pat[i] == WILDCARD_DEF || cur_pat[i] == b) exp_word[i] = 1'b0;
  endfunction

  task automatic do_start();
    @(negedge i_clk); i_cfg_start = 1'b1;
    @(negedge i_clk); i_cfg_start = 1'b0;
  endtask

  task automatic send_pat(input bit with_last);
    for (int i = 0; i < cur_pat.size(); i++) begin
      @(negedge i_clk);
      i_pat_valid = 1'b1;
      i_pat_data  = cur_pat[i];
      i_pat_last  = with_last && (i == cur_pat.size() - 1);
    end
    @(negedge i_clk);
    i_pat_valid = 1'b0;
    i_pat_last  = 1'b0;
  endtask

  task automatic run_load(input string nm, input bit st, input int poke_cyc, input bit hold_valid);
    int len, nlit, cyc, done_at, bad, nwr, rdy, lat, d0;
    logic [7:0] wc;
    len = cur_pat.size(); nlit = 0; wc = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (cur_pat[i] == WILDCARD_DEF) wc[i] = 1'b1;
      else nlit++;
    end
    lat = 257 + len;
`ifdef SNI_LOADER_READBACK_EN
    lat = lat + len + 1;
`endif
    if (st) do_start();
    send_pat(1'b1);
    if (hold_valid) i_pat_valid = 1'b1;
    d0 = done_cnt; cyc = 0; done_at = -1; bad = 0; nwr = 0; rdy = 0;
    while (done_at < 0 && cyc < 900) begin
      @(posedge i_clk); #1; cyc++;
      i_cfg_start = (cyc == poke_cyc);
      if (o_pat_ready) rdy++;
      if (o_tbl_we) begin
        nwr++;
        if (cyc <= 256) begin
          if (o_tbl_addr != 8'(cyc - 1) || o_tbl_din != ~wc) bad++;
        end else if (cyc > 256 + len || cur_pat[cyc-257] == WILDCARD_DEF ||
                     o_tbl_addr != cur_pat[cyc-257] || o_tbl_din != exp_word(cur_pat[cyc-257])) begin
          bad++;
        end
      end else if (cyc <= 256 || (cyc <= 256 + len && cur_pat[cyc-257] != WILDCARD_DEF)) begin
        bad++;
      end
      if (o_done) done_at = cyc;
    end
    i_pat_valid = 1'b0;
    i_cfg_start = 1'b0;
    check_eq({nm, ":latency"}, 32'(done_at), 32'(lat));
    check_eq({nm, ":wr_seq"}, 32'(bad), 32'd0);
    check_eq({nm, ":wr_cnt"}, 32'(nwr), 32'(256 + nlit));
    check_eq({nm, ":wc_mask"}, 32'(o_wc_mask), 32'(wc));
    check_eq({nm, ":accept_idx"}, 32'(o_accept_idx), 32'(len - 1));
    check_eq({nm, ":busy_at_done"}, 32'(o_busy), 32'd0);
    if (hold_valid) check_eq({nm, ":ready_outside"}, 32'(rdy), 32'd0);
`ifdef SNI_LOADER_READBACK_EN
    check_eq({nm, ":verify_err"}, 32'(o_verify_err), 32'(corrupt_b));
`endif
    bad = 0;
    for (int a = 0; a < TBL_DEPTH; a++) if (ram[a] !== exp_word(8'(a))) bad++;
    check_eq({nm, ":ram"}, 32'(bad), 32'd0);
    repeat (4) @(negedge i_clk);
    check_eq({nm, ":done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check_eq({nm, ":idle_after"}, {30'd0, o_busy, o_pat_ready}, 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    all_outs = {o_pat_ready, o_tbl_we, o_tbl_addr, o_tbl_din, o_wc_mask,
                o_accept_idx, o_busy, o_done, o_err};
  endfunction

  initial begin
    logic [7:0] alph [4];
    int unsigned we0, d0, guard;
    alph[0] = 8'h61; alph[1] = 8'h62; alph[2] = 8'h63; alph[3] = WILDCARD_DEF;
    i_rst_n = 1'b0; i_cfg_start = 1'b0; i_pat_valid = 1'b0; i_pat_last = 1'b0; i_pat_data = 8'h00;
    repeat (3) @(negedge i_clk);
    check_eq("reset_outs", all_outs(), 32'd0);
    i_rst_n = 1'b1;

    cur_pat = '{8'h61, 8'h62, 8'h2A, 8'h64};
    run_load("ab*d", 1'b1, 0, 1'b0);
    check_eq("ab*d:word_a", 32'(ram[8'h61]), 32'hFA);
    check_eq("ab*d:word_d", 32'(ram[8'h64]), 32'hF3);

    cur_pat = '{8'h61, 8'h61, 8'h62, 8'h61};
    run_load("aaba", 1'b1, 258, 1'b1);
    check_eq("aaba:word_a", 32'(ram[8'h61]), 32'hF4);
    check_eq("aaba:word_b", 32'(ram[8'h62]), 32'hFB);

    // Overflow: nine bytes without last.
    cur_pat.delete();
    for (int i = 0; i < 9; i++) cur_pat.push_back(8'($urandom_range(8'h30, 8'h39)));
    we0 = we_cnt;
    do_start();
    send_pat(1'b0);
    repeat (3) @(negedge i_clk);
    check_eq("ovf:err", 32'(o_err), 32'd1);
    check_eq("ovf:idle", {30'd0, o_busy, o_pat_ready}, 32'd0);
    check_eq("ovf:no_writes", 32'(we_cnt - we0), 32'd0);
    do_start();
    check_eq("ovf:err_cleared", 32'(o_err), 32'd0);
    check_eq("ovf:capturing", 32'(o_pat_ready), 32'd1);
    cur_pat = '{8'h78, 8'h2A};
    run_load("post_ovf", 1'b0, 0, 1'b0);

    // Asynchronous reset in the middle of the clear sweep.
    cur_pat = '{8'h61, 8'h62, 8'h63};
    do_start();
    send_pat(1'b1);
    guard = 0;
    while (!(o_tbl_we && o_tbl_addr == 8'd100) && guard < 400) begin
      @(posedge i_clk); #1; guard++;
    end
    check_eq("rst:reached_addr100", 32'(o_tbl_addr), 32'd100);
    #2 i_rst_n = 1'b0;
    #1 check_eq("rst:outs_async", all_outs(), 32'd0);
    d0 = done_cnt; we0 = we_cnt;
    repeat (5) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (300) @(negedge i_clk);
    check_eq("rst:no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("rst:no_writes", 32'(we_cnt - we0), 32'd0);
    cur_pat = '{8'h6C, 8'h64, 8'h61, 8'h70, 8'h73};
    run_load("ldaps", 1'b1, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 8);
      cur_pat.delete();
      for (int i = 0; i < n; i++) begin
        int pick;
        pick = $urandom_range(0, 4);
        cur_pat.push_back(pick == 4 ? 8'($urandom) : alph[pick]);
      end
      run_load($sformatf("rand%0d", t), 1'b1, (t % 2 == 0) ? 257 + n : 0, t[0]);
    end

`ifdef SNI_LOADER_READBACK_EN
    corrupt_b = 1'b1;
    cur_pat = '{8'h61, 8'h62, 8'h2A, 8'h64};
    run_load("corrupt_b", 1'b1, 0, 1'b0);
    corrupt_b = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
